// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the toggle-strobed ALU.
// Owns the register file and pc, and retires one instruction every five cycles.
module alu_issue_ctrl #(
   parameter int DATA_W = 13,
   parameter int PC_W   = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   output logic              ALUSTART,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_branch,
   output logic [PC_W-1:0]   pc,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              done,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_ISSUE, S_CAPTURE, S_WB
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUBI = 3'b011;
   localparam logic [2:0] OP_BR   = 3'b100;
   localparam logic [2:0] OP_BEQ  = 3'b101;
   localparam logic [2:0] OP_STI  = 3'b110;
   localparam logic [2:0] OP_LDI  = 3'b111;

   state_t              state_q, state_d;
   logic [15:0]         instr_q, instr_d;
   logic [DATA_W-1:0]   regs_q [8];
   logic [DATA_W-1:0]   regs_d [8];
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [2:0]          alu_sel_q, alu_sel_d;
   logic                start_q, start_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                br_q, br_d;
   logic                mem_we_q, mem_we_d;
   logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                done_q, done_d;

   logic [2:0]          op_w, rd_w, rs_w, rt_w;
   logic [DATA_W-1:0]   imm_w;

   assign op_w  = instr_q[15:13];
   assign rd_w  = instr_q[12:10];
   assign rs_w  = instr_q[9:7];
   assign rt_w  = instr_q[6:4];
   assign imm_w = {{(DATA_W-7){1'b0}}, instr_q[6:0]};

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      regs_d      = regs_q;
      pc_d        = pc_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      start_d     = start_q;
      res_d       = res_q;
      br_d        = br_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_sel_d = op_w;
            unique case (op_w)
               OP_ADD, OP_SUB, OP_BEQ: begin
                  alu_a_d = regs_q[rs_w];
                  alu_b_d = regs_q[rt_w];
               end
               OP_ADDI, OP_SUBI: begin
                  alu_a_d = regs_q[rs_w];
                  alu_b_d = imm_w;
               end
               OP_BR: begin
                  alu_a_d = regs_q[rs_w];
                  alu_b_d = '0;
               end
               OP_STI, OP_LDI: begin
                  alu_a_d = '0;
                  alu_b_d = imm_w;
               end
            endcase
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            start_d = ~start_q;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // done/mem_we flop here so they sit high for exactly the WB cycle
            res_d  = alu_result;
            br_d   = alu_branch;
            done_d = 1'b1;
            if (op_w == OP_STI) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = regs_q[rd_w];
               mem_wdata_d = alu_result;
            end
            state_d = S_WB;
         end
         S_WB: begin
            pc_d = pc_q + PC_W'(1);
            unique case (op_w)
               OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LDI:
                  regs_d[rd_w] = res_q;
               OP_BR:
                  if (br_q) pc_d = res_q[PC_W-1:0];
               OP_BEQ:
                  if (br_q) pc_d = regs_q[rd_w][PC_W-1:0];
               OP_STI: ;
            endcase
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         pc_q        <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         start_q     <= 1'b0;
         res_q       <= '0;
         br_q        <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         regs_q      <= regs_d;
         pc_q        <= pc_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         start_q     <= start_d;
         res_q       <= res_d;
         br_q        <= br_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign ALUSTART    = start_q;
   assign pc          = pc_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign done        = done_q;
   assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a toggle-triggered ALU model.
// Expected values are hand-computed from the instruction sequence.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [12:0] alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic        ALUSTART;
   logic [12:0] alu_result = '0;
   logic        alu_branch = 1'b0;
   logic [12:0] pc;
   logic        mem_we;
   logic [12:0] mem_addr, mem_wdata;
   logic        done;
   logic [2:0]  dbg_addr = '0;
   logic [12:0] dbg_data;

   int n_chk = 0;
   int n_fail = 0;
   int tog = 0;
   int we_cnt = 0;
   int done_cnt = 0;
   logic        last_we;
   logic [12:0] last_addr, last_wdata;

   alu_issue_ctrl #(.DATA_W(13), .PC_W(13)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .ALUSTART(ALUSTART),
      .alu_result(alu_result), .alu_branch(alu_branch),
      .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // ALU model: evaluates only when the strobe changes
   always @(ALUSTART) begin
      if (!reset) tog++;
      if (alu_sel == 3'b001 || alu_sel == 3'b011)
         alu_result = alu_a - alu_b;
      else
         alu_result = alu_a + alu_b;
      if (alu_sel == 3'b101)      alu_branch = (alu_a == alu_b);
      else if (alu_sel == 3'b100) alu_branch = (alu_a != 13'd0);
      else                        alu_branch = 1'b0;
   end

   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (done)   done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] idx,
                          input logic [12:0] exp);
      dbg_addr = idx;
      #1;
      chk(tag, {19'd0, dbg_data}, {19'd0, exp});
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op,
      input logic [2:0] rd, input logic [2:0] rs, input logic [6:0] lo);
      return {op, rd, rs, lo};
   endfunction

   task automatic run_instr(input logic [15:0] ins);
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready", {31'd0, instr_ready}, 32'd1);
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 16'hFFFF;
      n = 0;
      while (!done && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 3);
      last_we = mem_we;
      last_addr = mem_addr;
      last_wdata = mem_wdata;
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int t0, w0, d0, rdy;

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_pc", {19'd0, pc}, 32'd0);
      chk("rst_start", {31'd0, ALUSTART}, 32'd0);
      chk("rst_sel", {29'd0, alu_sel}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 13'd0);

      // LDI R1,5; LDI R2,3; SUB R3,R1,R2
      t0 = tog;
      run_instr(enc(3'b111, 3'd1, 3'd0, 7'd5));
      run_instr(enc(3'b111, 3'd2, 3'd0, 7'd3));
      run_instr(enc(3'b001, 3'd3, 3'd1, {3'd2, 4'd0}));
      chk_reg("r1", 3'd1, 13'd5);
      chk_reg("r2", 3'd2, 13'd3);
      chk_reg("sub_r3", 3'd3, 13'd2);
      chk("pc3", {19'd0, pc}, 32'd3);
      chk("toggles3", tog - t0, 3);

      // negative result and wrap to zero
      run_instr(enc(3'b001, 3'd4, 3'd2, {3'd1, 4'd0}));
      chk_reg("sub_r4", 3'd4, 13'h1FFE);
      run_instr(enc(3'b010, 3'd5, 3'd4, 7'd2));
      chk_reg("addi_wrap", 3'd5, 13'h0000);
      chk("pc5", {19'd0, pc}, 32'd5);

      // BEQ taken to R6, then not taken
      run_instr(enc(3'b111, 3'd6, 3'd0, 7'h40));
      run_instr(enc(3'b101, 3'd6, 3'd1, {3'd1, 4'd0}));
      chk("beq_taken", {19'd0, pc}, 32'h40);
      chk_reg("beq_r6", 3'd6, 13'h40);
      run_instr(enc(3'b101, 3'd6, 3'd1, {3'd2, 4'd0}));
      chk("beq_not", {19'd0, pc}, 32'h41);

      // store
      w0 = we_cnt;
      run_instr(enc(3'b110, 3'd2, 3'd0, 7'h7F));
      chk("sti_we", {31'd0, last_we}, 32'd1);
      chk("sti_addr", {19'd0, last_addr}, 32'd3);
      chk("sti_data", {19'd0, last_wdata}, 32'h7F);
      chk("sti_pulses", we_cnt - w0, 1);
      chk("sti_pc", {19'd0, pc}, 32'h42);
      run_instr(enc(3'b111, 3'd4, 3'd0, 7'd1));
      chk("hold_addr", {19'd0, mem_addr}, 32'd3);
      chk("hold_we", {31'd0, last_we}, 32'd0);
      chk_reg("sti_r2", 3'd2, 13'd3);

      // BR via R1 (res = 5)
      run_instr(enc(3'b100, 3'd0, 3'd1, 7'd0));
      chk("br_pc", {19'd0, pc}, 32'd5);

      // pc wrap from 0x1FFF
      run_instr(enc(3'b011, 3'd7, 3'd0, 7'd1));
      chk_reg("subi_r7", 3'd7, 13'h1FFF);
      run_instr(enc(3'b101, 3'd7, 3'd0, {3'd0, 4'd0}));
      chk("pc_max", {19'd0, pc}, 32'h1FFF);
      run_instr(enc(3'b111, 3'd3, 3'd0, 7'd1));
      chk("pc_wrap", {19'd0, pc}, 32'd0);

      // reset during ISSUE
      run_instr(enc(3'b111, 3'd7, 3'd0, 7'd9));
      chk("pre_rst_start", {31'd0, ALUSTART}, 32'd1);
      @(negedge clk);
      instr = enc(3'b111, 3'd1, 3'd0, 7'd5);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_start", {31'd0, ALUSTART}, 32'd0);
      chk("mid_b", {19'd0, alu_b}, 32'd0);
      chk("mid_sel", {29'd0, alu_sel}, 32'd0);
      chk("mid_pc", {19'd0, pc}, 32'd0);
      chk("mid_addr", {19'd0, mem_addr}, 32'd0);
      chk("mid_wdata", {19'd0, mem_wdata}, 32'd0);
      chk_reg("mid_r7", 3'd7, 13'd0);
      chk_reg("mid_r1", 3'd1, 13'd0);
      @(negedge clk);
      reset = 1'b0;
      d0 = done_cnt;
      repeat (6) @(negedge clk);
      chk("mid_nodone", done_cnt - d0, 0);
      chk("mid_ready", {31'd0, instr_ready}, 32'd1);
      chk("mid_pc2", {19'd0, pc}, 32'd0);

      // instr_valid held high: ADDI R5,R5,1 accepted once per 5 cycles
      t0 = tog;
      d0 = done_cnt;
      rdy = 0;
      instr = enc(3'b010, 3'd5, 3'd5, 7'd1);
      instr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (instr_ready) rdy++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("cont_accepts", rdy, 4);
      chk("cont_dones", done_cnt - d0, 4);
      chk("cont_toggles", tog - t0, 4);
      chk_reg("cont_r5", 3'd5, 13'd4);
      chk("cont_pc", {19'd0, pc}, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
